// File: rtl/gpio_regbank.sv
// gpio_regbank: memory-mapped GPIO register bank. It provides pin synchronisation,
// edge-capture interrupts, atomic set/clear of the output data, and error responses.
// Latency: a req sampled at edge k is acknowledged after edge k+1. Writes commit at edge k.
// Backpressure: none. The bank accepts one access every cycle and ack cannot be stalled.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   req/addr/wben/r_wn/wdata -> ack/rdata/err : pipelined register access
//   gpio_pin_in           - asynchronous pin inputs
//   gpio_out, gpio_oe     - output data and output enables (1 = drive)
//   irq                   - registered OR of masked interrupt status
module gpio_regbank #(
  parameter int          GPIO_WIDTH   = 16,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] CHIP_NAME    = 32'h48524a44,
  parameter logic [31:0] CHIP_VERSION = 32'h00000002
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [5:2]            addr,
  input  logic [3:0]            wben,
  input  logic                  r_wn,
  input  logic [31:0]           wdata,
  output logic                  ack,
  output logic [31:0]           rdata,
  output logic                  err,
  input  logic [GPIO_WIDTH-1:0] gpio_pin_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [3:0] A_ID      = 4'd0;
  localparam logic [3:0] A_VERSION = 4'd1;
  localparam logic [3:0] A_TRI     = 4'd2;
  localparam logic [3:0] A_PIN     = 4'd3;
  localparam logic [3:0] A_DOUT    = 4'd4;
  localparam logic [3:0] A_MASK    = 4'd5;
  localparam logic [3:0] A_RISE    = 4'd6;
  localparam logic [3:0] A_FALL    = 4'd7;
  localparam logic [3:0] A_STAT    = 4'd8;
  localparam logic [3:0] A_SET     = 4'd9;
  localparam logic [3:0] A_CLR     = 4'd10;
  localparam logic [3:0] A_SCRATCH = 4'd11;

  // Register state
  logic [GPIO_WIDTH-1:0] tri_q, tri_d;
  logic [GPIO_WIDTH-1:0] dout_q, dout_d;
  logic [GPIO_WIDTH-1:0] mask_q, mask_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] stat_q, stat_d;
  logic [31:0]           scratch_q, scratch_d;

  // Pin path
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] pin_sync;
  logic [GPIO_WIDTH-1:0] set_ev;

  // Response pipeline: stage 1 holds the response formed at the request edge,
  // and the output stage presents it one edge later.
  logic        ack1_q, ack1_d;
  logic        err1_q, err1_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        ack_q, err_q, irq_q;
  logic [31:0] rdata_q;

  logic [31:0]           lane_m;
  logic [GPIO_WIDTH-1:0] pin_m;
  logic [GPIO_WIDTH-1:0] wd_p;
  logic                  illegal;
  logic                  wr_ok;
  logic [31:0]           rd_val;

  assign pin_sync = sync_q[SYNC_STAGES-1];
  assign set_ev   = (pin_sync & ~prev_q & rise_en_q) | (~pin_sync & prev_q & fall_en_q);

  always_comb begin
    lane_m  = {{8{wben[3]}}, {8{wben[2]}}, {8{wben[1]}}, {8{wben[0]}}};
    pin_m   = lane_m[GPIO_WIDTH-1:0];
    wd_p    = wdata[GPIO_WIDTH-1:0];
    // Unmapped words, and writes to the read-only words, are rejected without side effects.
    illegal = (addr >= 4'd12) ||
              (!r_wn && (addr == A_ID || addr == A_VERSION || addr == A_PIN));
    wr_ok   = req && !r_wn && !illegal;

    rd_val = '0;
    case (addr)
      A_ID:      rd_val = CHIP_NAME;
      A_VERSION: rd_val = CHIP_VERSION;
      A_TRI:     rd_val = 32'(tri_q);
      A_PIN:     rd_val = 32'(pin_sync);
      A_DOUT:    rd_val = 32'(dout_q);
      A_MASK:    rd_val = 32'(mask_q);
      A_RISE:    rd_val = 32'(rise_en_q);
      A_FALL:    rd_val = 32'(fall_en_q);
      A_STAT:    rd_val = 32'(stat_q);
      A_SCRATCH: rd_val = scratch_q;
      default:   rd_val = '0;
    endcase

    tri_d     = tri_q;
    dout_d    = dout_q;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    stat_d    = stat_q;
    scratch_d = scratch_q;
    if (wr_ok) begin
      case (addr)
        A_TRI:     tri_d     = (tri_q     & ~pin_m) | (wd_p & pin_m);
        A_DOUT:    dout_d    = (dout_q    & ~pin_m) | (wd_p & pin_m);
        A_MASK:    mask_d    = (mask_q    & ~pin_m) | (wd_p & pin_m);
        A_RISE:    rise_en_d = (rise_en_q & ~pin_m) | (wd_p & pin_m);
        A_FALL:    fall_en_d = (fall_en_q & ~pin_m) | (wd_p & pin_m);
        A_STAT:    stat_d    = stat_q & ~(wd_p & pin_m);
        A_SET:     dout_d    = dout_q | (wd_p & pin_m);
        A_CLR:     dout_d    = dout_q & ~(wd_p & pin_m);
        A_SCRATCH: scratch_d = (scratch_q & ~lane_m) | (wdata & lane_m);
        default:   ;
      endcase
    end
    // A new edge event overrides a same-cycle write-1-to-clear.
    stat_d = stat_d | set_ev;

    ack1_d   = req;
    err1_d   = req && illegal;
    rdata1_d = (req && r_wn && !illegal) ? rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tri_q     <= '0;
      dout_q    <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      scratch_q <= '0;
      sync_q    <= '0;
      prev_q    <= '0;
      ack1_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata1_q  <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      tri_q     <= tri_d;
      dout_q    <= dout_d;
      mask_q    <= mask_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      scratch_q <= scratch_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_pin_in};
      prev_q    <= pin_sync;
      ack1_q    <= ack1_d;
      err1_q    <= err1_d;
      rdata1_q  <= rdata1_d;
      ack_q     <= ack1_q;
      err_q     <= err1_q;
      rdata_q   <= rdata1_q;
      irq_q     <= |(stat_q & mask_q);
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign gpio_out = dout_q;
  assign gpio_oe  = tri_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_regbank.sv
module tb_gpio_regbank;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [5:2]  addr;
  logic [3:0]  wben;
  logic        r_wn;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic [15:0] pins;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  gpio_regbank #(.GPIO_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .wben(wben), .r_wn(r_wn),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .gpio_pin_in(pins),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        er;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cycle++;

  // Monitor: every ack must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    if (cycle > 0) begin
      if (ack === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ack cycle=%0d rdata=%h err=%b", cycle, rdata, err);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cycle != e.cyc || rdata !== e.rd || err !== e.er) begin
            fails++;
            $display("FAIL %s: got cycle=%0d rdata=%h err=%b, want cycle=%0d rdata=%h err=%b",
                     e.name, cycle, rdata, err, e.cyc, e.rd, e.er);
          end
        end
      end else if (q.size() != 0 && q[0].cyc < cycle) begin
        exp_t e;
        e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL %s: no ack by cycle %0d (want ack at cycle %0d)", e.name, cycle, e.cyc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // One bus access. The expected response is queued for the monitor; ack is
  // due one full cycle after the sampling edge.
  task automatic bus(input string name, input logic rd, input logic [3:0] a,
                     input logic [3:0] be, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    req   = 1'b1;
    r_wn  = rd;
    addr  = a;
    wben  = be;
    wdata = wd;
    e.cyc  = cycle + 2;
    e.rd   = exp_rd;
    e.er   = exp_err;
    e.name = name;
    q.push_back(e);
    cyc();
    req = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp_rd,
                    input logic exp_err);
    bus(name, 1'b1, a, 4'hf, 32'h0, exp_rd, exp_err);
  endtask

  task automatic wr(input string name, input logic [3:0] a, input logic [3:0] be,
                    input logic [31:0] wd, input logic exp_err);
    bus(name, 1'b0, a, be, wd, 32'h0, exp_err);
  endtask

  initial begin
    reset = 1'b1;
    pins  = '0;
    // Requests during reset are ignored; the monitor flags any ack they cause.
    req   = 1'b1;
    r_wn  = 1'b1;
    addr  = 4'd0;
    wben  = 4'hf;
    wdata = '0;
    idle(2);
    reset = 1'b0;
    req   = 1'b0;
    idle(2);
    check("reset_gpio_out", 32'(gpio_out), 32'h0);
    check("reset_gpio_oe", 32'(gpio_oe), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);

    // ID and VERSION back to back
    rd("rd_id", 4'd0, 32'h48524a44, 1'b0);
    rd("rd_version", 4'd1, 32'h00000002, 1'b0);
    idle(3);

    // Byte lanes and width truncation
    wr("wr_scratch_full", 4'd11, 4'b1111, 32'ha5a5a5a5, 1'b0);
    wr("wr_scratch_lanes", 4'd11, 4'b0101, 32'h12345678, 1'b0);
    rd("rd_scratch", 4'd11, 32'ha534a578, 1'b0);
    wr("wr_tristate", 4'd2, 4'b1111, 32'hffffffff, 1'b0);
    rd("rd_tristate", 4'd2, 32'h0000ffff, 1'b0);
    check("gpio_oe", 32'(gpio_oe), 32'h0000ffff);
    idle(3);

    // Set/clear, three back-to-back accesses
    wr("wr_dout", 4'd4, 4'hf, 32'h000000f0, 1'b0);
    wr("wr_set", 4'd9, 4'hf, 32'h00000003, 1'b0);
    wr("wr_clr", 4'd10, 4'hf, 32'h00000010, 1'b0);
    check("gpio_out_setclr", 32'(gpio_out), 32'h000000e3);
    rd("rd_dout", 4'd4, 32'h000000e3, 1'b0);
    wr("wr_set_lane1_only", 4'd9, 4'b0010, 32'h00000101, 1'b0);
    check("gpio_out_set_lane", 32'(gpio_out), 32'h000001e3);
    wr("wr_clr_restore", 4'd10, 4'hf, 32'h00000100, 1'b0);
    idle(3);

    // Rising edge on pin 2 to irq
    wr("wr_rise_en", 4'd6, 4'hf, 32'h00000004, 1'b0);
    wr("wr_irq_mask", 4'd5, 4'hf, 32'h00000004, 1'b0);
    idle(2);
    pins[2] = 1'b1;
    cyc();                        // E0
    cyc();                        // E0+1
    cyc();                        // E0+2: status set, irq not yet
    check("irq_before", 32'(irq), 32'h0);
    cyc();                        // E0+3
    check("irq_assert", 32'(irq), 32'h1);
    rd("rd_status_rise", 4'd8, 32'h00000004, 1'b0);
    rd("rd_pinstate", 4'd3, 32'h00000004, 1'b0);
    wr("w1c_bit2", 4'd8, 4'hf, 32'h00000004, 1'b0);
    check("irq_held_at_w1c", 32'(irq), 32'h1);
    cyc();
    check("irq_deassert", 32'(irq), 32'h0);
    rd("rd_status_clear", 4'd8, 32'h0, 1'b0);
    idle(3);

    // Falling edge on pin 0 coinciding with a W1C of bit 0
    pins[0] = 1'b1;
    idle(4);
    wr("wr_fall_en", 4'd7, 4'hf, 32'h00000001, 1'b0);
    idle(2);
    pins[0] = 1'b0;
    cyc();                        // E0
    cyc();                        // E0+1
    wr("w1c_conflict", 4'd8, 4'hf, 32'h00000001, 1'b0);   // sampled at E0+2
    rd("rd_status_conflict", 4'd8, 32'h00000001, 1'b0);
    wr("w1c_bit0", 4'd8, 4'hf, 32'h00000001, 1'b0);
    rd("rd_status_bit0_clear", 4'd8, 32'h0, 1'b0);
    idle(3);

    // Illegal accesses produce an error with no side effects.
    rd("rd_unmapped13", 4'd13, 32'h0, 1'b1);
    wr("wr_pinstate", 4'd3, 4'hf, 32'hffffffff, 1'b1);
    wr("wr_id", 4'd0, 4'hf, 32'hffffffff, 1'b1);
    wr("wr_unmapped12", 4'd12, 4'hf, 32'hffffffff, 1'b1);
    rd("rd_id_after", 4'd0, 32'h48524a44, 1'b0);
    rd("rd_scratch_after", 4'd11, 32'ha534a578, 1'b0);
    rd("rd_dout_after", 4'd4, 32'h000000e3, 1'b0);
    rd("rd_set_out", 4'd9, 32'h0, 1'b0);
    rd("rd_clr_out", 4'd10, 32'h0, 1'b0);
    idle(5);

    check("pending_responses", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_regbank.md
# gpio_regbank

Parametrised successor to the fixed 16-bit GPIO/timer register file. It is a memory-mapped register bank serving a GPIO port of GPIO_WIDTH pins, connected to the bus-side master through a pipelined request/acknowledge handshake. Over the original it adds:
- pin synchronisation;
- per-pin rising/falling edge interrupt capture with a write-1-to-clear status register and an `irq` output;
- atomic set/clear of output data;
- an error response for illegal accesses.

## Interface
Parameters:
- GPIO_WIDTH, 16, number of GPIO pins, legal range 1..32
- SYNC_STAGES, 2, pin synchroniser depth, legal range 2..3
- CHIP_NAME, 32'h48524a44, value returned by ID
- CHIP_VERSION, 32'h00000002, value returned by VERSION

Ports:
- clk  in  1  master clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, sampled every cycle
- addr  in  [5:2]  32-bit word index
- wben  in  4  per-byte-lane write enables
- r_wn  in  1  1 = read, 0 = write
- wdata  in  32  write data
- ack  out  1  one-cycle response strobe
- rdata  out  32  read data, valid while ack=1
- err  out  1  illegal access flag, valid while ack=1
- gpio_pin_in  in  GPIO_WIDTH  asynchronous pin inputs
- gpio_out  out  GPIO_WIDTH  output data (DATA_OUT)
- gpio_oe  out  GPIO_WIDTH  output enables (TRISTATE; 1 = drive)
- irq  out  1  registered interrupt request

## Operation
Register map (word index: name, access):
- 0: ID, RO, returns CHIP_NAME.
- 1: VERSION, RO, returns CHIP_VERSION.
- 2: TRISTATE, RW; drives gpio_oe.
- 3: PINSTATE, RO; returns the synchroniser output.
- 4: DATA_OUT, RW; drives gpio_out.
- 5: IRQ_MASK, RW.
- 6: RISE_EN, RW.
- 7: FALL_EN, RW.
- 8: IRQ_STATUS, W1C.
- 9: SET_OUT, WO; writing 1 sets the corresponding DATA_OUT bits. Reads return 0 with err=0.
- 10: CLR_OUT, WO; writing 1 clears the corresponding DATA_OUT bits. Reads return 0 with err=0.
- 11: SCRATCH, RW, full 32 bits.
- 12–15: unmapped.

Access rules:
- Width rule: pin-sized registers occupy bits [GPIO_WIDTH-1:0]. Upper bits read 0 and ignore writes.
- Byte-lane rule: byte lane n is written only when wben[n]=1. This applies to RW, W1C, SET_OUT and CLR_OUT writes alike.
- Error response (ack with err=1, rdata=0, no state change) for:
  - any access to an unmapped address;
  - any write to ID, VERSION or PINSTATE.
- Reads have no side effects.

Edge capture:
- For each pin i, `sync` is the output of a SYNC_STAGES-deep flop chain and `prev` is `sync` delayed by one cycle.
- `rise = sync & ~prev`; `fall = ~sync & prev`.
- Set condition: STATUS[i] is set when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
- Same-cycle conflict: if the set condition and a W1C write of 1 to the same bit occur in the same cycle, the set wins and the bit stays 1.
- irq is registered: irq <= |(STATUS & IRQ_MASK).

## Timing
Reset:
- While reset=1, req is ignored.
- At the first edge with reset=1, all of the following go to 0:
  - outputs: ack, err, rdata, gpio_out, gpio_oe, irq;
  - all RW/W1C registers, SCRATCH, sync chain and prev.
- Because RISE_EN and FALL_EN reset to 0, pins high at reset release produce no status bits.
- A request whose ack would fall in a cycle with reset=1 receives no ack.

Handshake:
- Fully pipelined: a req sampled at edge k produces ack=1 for exactly one cycle after edge k+1, with rdata and err valid in that cycle.
- req may be asserted every cycle; throughput is one access per cycle.
- When ack=0, rdata=0 and err=0.

Write latency:
- A write accepted at edge k updates its register at edge k.
- A read accepted at edge k+1 returns the new value.
- gpio_out and gpio_oe change at edge k.

Pin path:
- A pin level that is stable across edge E0 appears in PINSTATE after edge E0+SYNC_STAGES-1.
- The STATUS bit sets at edge E0+SYNC_STAGES.
- irq asserts at edge E0+SYNC_STAGES+1.

irq deassert: irq deasserts one edge after the W1C write or mask write that removes the last enabled status bit.

## Test plan
- **Reset and ID:** reset 2 cycles, then read addr 0 and addr 1 → ack one cycle after req; rdata 48524a44 then 00000002; err=0; gpio_out=gpio_oe=0.
- **Byte enables:** GPIO_WIDTH=16. Write SCRATCH a5a5a5a5 with wben=1111, then 12345678 with wben=0101 → SCRATCH reads a534a578. Write TRISTATE ffffffff → reads 0000ffff.
- **Set/clear and throughput:** back-to-back writes DATA_OUT=00f0, SET_OUT=0003, CLR_OUT=0010 → gpio_out=00e3, with three consecutive ack cycles.
- **Rising edge to irq:** RISE_EN[2]=1, IRQ_MASK[2]=1, pin2 0→1 before edge E0 (SYNC_STAGES=2):
  - STATUS=0004 at E0+2 and irq=1 at E0+3;
  - W1C 0004 → irq=0 one edge later.
- **Set-vs-clear conflict:** W1C of bit 0 in the same cycle as a bit-0 falling edge (FALL_EN[0]=1) → STATUS[0] remains 1.
- **Illegal access:** read addr 13, write addr 3, write addr 0 → each acks with err=1, rdata=0; no register changes. Read addr 9 → err=0, rdata=0.
